// File: rtl/life_pkg.sv
// Shared types and constants for the Game of Life generation scheduler.
package life_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'b000,
      ST_LOAD    = 3'b001,
      ST_COMPUTE = 3'b010,
      ST_COPY    = 3'b011,
      ST_WAIT    = 3'b100
   } sched_state_t;

   localparam int unsigned CELLS_DEFAULT = 49;
   localparam int unsigned GRID_DIM      = 7;

   // grid_shift_sel encodings
   localparam logic SEL_EXTERNAL = 1'b0;
   localparam logic SEL_RECIRC   = 1'b1;

endpackage

// File: rtl/life_period_timer.sv
// Loadable down-counter with a zero flag; paces the inter-generation wait.
module life_period_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] count_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_q <= count_q - W'(1);
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/life_gen_scheduler.sv
// LOAD / COMPUTE / COPY / WAIT sequencer for the serial-shift Life grid.
// Optional still-life detection is enabled by defining LIFE_STILL_DETECT_EN.
module life_gen_scheduler
   import life_pkg::*;
#(
   parameter int unsigned CELLS    = CELLS_DEFAULT,
   parameter int unsigned PERIOD_W = 8,
   parameter int unsigned GEN_W    = 16
) (
   input  logic                clock,
   input  logic                reset,
`ifdef LIFE_STILL_DETECT_EN
   input  logic                grid_old_bit,
   input  logic                grid_new_bit,
   output logic                still,
`endif
   input  logic                cmd_load,
   input  logic                cmd_step,
   input  logic                cmd_run,
   input  logic                cmd_stop,
   input  logic [PERIOD_W-1:0] period,
   input  logic                bit_in,
   input  logic                bit_valid,
   output logic                bit_ready,
   output logic                grid_shift_en,
   output logic                grid_shift_sel,
   output logic                grid_bit_out,
   output logic                grid_compute,
   output logic [2:0]          state_out,
   output logic [GEN_W-1:0]    gen_count,
   output logic                busy,
   output logic                done
);

   localparam int unsigned CNT_W = (CELLS > 1) ? $clog2(CELLS) : 1;
   localparam logic [CNT_W-1:0] CELL_LAST = CNT_W'(CELLS - 1);

   sched_state_t     state_q, state_d;
   logic [CNT_W-1:0] cell_q, cell_d;
   logic [GEN_W-1:0] gen_q, gen_d;
   logic             running_q, running_d;
   logic             stop_pend_q, stop_pend_d;
   logic             done_q, done_d;
   logic             timer_load, timer_dec, timer_zero;
   logic             cell_last, halt, still_now;

`ifdef LIFE_STILL_DETECT_EN
   logic mism_q, mism_d;
   logic still_q, still_d;
   assign still_now = ~(mism_q | (grid_old_bit ^ grid_new_bit));
   assign still     = still_q;
`else
   assign still_now = 1'b0;
`endif

   // Timer is loaded with period-1 so WAIT lasts exactly period cycles.
   life_period_timer #(.W(PERIOD_W)) u_timer (
      .clock      (clock),
      .reset      (reset),
      .load_i     (timer_load),
      .load_val_i (period - PERIOD_W'(1)),
      .dec_i      (timer_dec),
      .zero_o     (timer_zero)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cell_q      <= '0;
         gen_q       <= '0;
         running_q   <= 1'b0;
         stop_pend_q <= 1'b0;
         done_q      <= 1'b0;
`ifdef LIFE_STILL_DETECT_EN
         mism_q      <= 1'b0;
         still_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cell_q      <= cell_d;
         gen_q       <= gen_d;
         running_q   <= running_d;
         stop_pend_q <= stop_pend_d;
         done_q      <= done_d;
`ifdef LIFE_STILL_DETECT_EN
         mism_q      <= mism_d;
         still_q     <= still_d;
`endif
      end
   end

   always_comb begin
      state_d        = state_q;
      cell_d         = cell_q;
      gen_d          = gen_q;
      running_d      = running_q;
      stop_pend_d    = stop_pend_q;
      done_d         = 1'b0;
      timer_load     = 1'b0;
      timer_dec      = 1'b0;
      bit_ready      = 1'b0;
      grid_shift_en  = 1'b0;
      grid_shift_sel = SEL_EXTERNAL;
      grid_compute   = 1'b0;
      cell_last      = (cell_q == CELL_LAST);
      halt           = ~running_q | stop_pend_q | cmd_stop | still_now;
`ifdef LIFE_STILL_DETECT_EN
      mism_d         = mism_q;
      still_d        = still_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_load) begin
               state_d = ST_LOAD;
               cell_d  = '0;
               gen_d   = '0;
`ifdef LIFE_STILL_DETECT_EN
               still_d = 1'b0;
`endif
            end else if (cmd_step) begin
               state_d   = ST_COMPUTE;
               running_d = 1'b0;
            end else if (cmd_run) begin
               state_d   = ST_COMPUTE;
               running_d = 1'b1;
            end
         end

         ST_LOAD: begin
            bit_ready = 1'b1;
            if (bit_valid) begin
               grid_shift_en = 1'b1;
               if (cell_last) begin
                  cell_d  = '0;
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  cell_d = cell_q + CNT_W'(1);
               end
            end
         end

         ST_COMPUTE: begin
            grid_compute = 1'b1;
            cell_d       = '0;
            state_d      = ST_COPY;
            if (cmd_stop) stop_pend_d = 1'b1;
`ifdef LIFE_STILL_DETECT_EN
            mism_d       = 1'b0;
`endif
         end

         ST_COPY: begin
            grid_shift_en  = 1'b1;
            grid_shift_sel = SEL_RECIRC;
            if (cmd_stop) stop_pend_d = 1'b1;
`ifdef LIFE_STILL_DETECT_EN
            mism_d = mism_q | (grid_old_bit ^ grid_new_bit);
`endif
            if (cell_last) begin
               cell_d = '0;
               gen_d  = gen_q + GEN_W'(1);
               done_d = 1'b1;
`ifdef LIFE_STILL_DETECT_EN
               if (still_now) still_d = 1'b1;
`endif
               if (halt) begin
                  state_d     = ST_IDLE;
                  running_d   = 1'b0;
                  stop_pend_d = 1'b0;
               end else if (period == '0) begin
                  state_d = ST_COMPUTE;
               end else begin
                  state_d    = ST_WAIT;
                  timer_load = 1'b1;
               end
            end else begin
               cell_d = cell_q + CNT_W'(1);
            end
         end

         ST_WAIT: begin
            if (cmd_stop) begin
               state_d     = ST_IDLE;
               running_d   = 1'b0;
               stop_pend_d = 1'b0;
            end else if (timer_zero) begin
               state_d = ST_COMPUTE;
            end else begin
               timer_dec = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign grid_bit_out = bit_in;
   assign state_out    = state_q;
   assign gen_count    = gen_q;
   assign busy         = (state_q != ST_IDLE);
   assign done         = done_q;

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Scoreboard bench for life_gen_scheduler: expected done events are queued by stimulus tasks
// and matched by a monitor that also tallies shift/compute activity between done pulses.
module tb_life_gen_scheduler;

   localparam int unsigned CELLS = 49;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_load = 1'b0, cmd_step = 1'b0, cmd_run = 1'b0, cmd_stop = 1'b0;
   logic [7:0]  period = '0;
   logic        bit_in = 1'b0, bit_valid = 1'b0;
   logic        bit_ready, grid_shift_en, grid_shift_sel, grid_bit_out, grid_compute;
   logic [2:0]  state_out;
   logic [15:0] gen_count;
   logic        busy, done;
`ifdef LIFE_STILL_DETECT_EN
   logic        grid_old_bit = 1'b0;
   logic        grid_new_bit = 1'b1;
   logic        still;
`endif

   life_gen_scheduler #(.CELLS(CELLS), .PERIOD_W(8), .GEN_W(16)) dut (
      .clock          (clock),
      .reset          (reset),
`ifdef LIFE_STILL_DETECT_EN
      .grid_old_bit   (grid_old_bit),
      .grid_new_bit   (grid_new_bit),
      .still          (still),
`endif
      .cmd_load       (cmd_load),
      .cmd_step       (cmd_step),
      .cmd_run        (cmd_run),
      .cmd_stop       (cmd_stop),
      .period         (period),
      .bit_in         (bit_in),
      .bit_valid      (bit_valid),
      .bit_ready      (bit_ready),
      .grid_shift_en  (grid_shift_en),
      .grid_shift_sel (grid_shift_sel),
      .grid_bit_out   (grid_bit_out),
      .grid_compute   (grid_compute),
      .state_out      (state_out),
      .gen_count      (gen_count),
      .busy           (busy),
      .done           (done)
   );

   always #5 clock = ~clock;

   typedef struct {
      int unsigned cyc;
      logic [15:0] gen;
      int unsigned n_ext;
      int unsigned n_rec;
      int unsigned n_comp;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned cyc = 0;
   int unsigned n_checks = 0;
   int unsigned n_fail = 0;
   logic [15:0] gen_exp = '0;
   int unsigned m_ext = 0, m_rec = 0, m_comp = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic tick_to(input int unsigned t);
      while (cyc < t) tick(1);
   endtask

   // Monitor: pop one expectation per done pulse and compare cycle, count and activity tallies.
   always @(negedge clock) begin
      exp_t e;
      if (reset) begin
         m_ext = 0; m_rec = 0; m_comp = 0;
      end else begin
         if (done) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: got done=1 with gen_count %0d, expected none (cycle %0d)",
                        gen_count, cyc);
            end else begin
               e = exp_q.pop_front();
               check("done_cycle", cyc, e.cyc);
               check("done_gen_count", gen_count, e.gen);
               check("ext_shifts", m_ext, e.n_ext);
               check("recirc_shifts", m_rec, e.n_rec);
               check("compute_pulses", m_comp, e.n_comp);
            end
            m_ext = 0; m_rec = 0; m_comp = 0;
         end
         if (grid_shift_en && !grid_shift_sel) m_ext++;
         if (grid_shift_en && grid_shift_sel) m_rec++;
         if (grid_compute) m_comp++;
         if (grid_bit_out !== bit_in) check("bit_passthrough", grid_bit_out, bit_in);
      end
   end

   task automatic do_load(input bit with_step);
      int unsigned n;
      int unsigned i;
      exp_t e;
      cmd_load = 1'b1;
      cmd_step = with_step;
      tick(1);
      cmd_load = 1'b0;
      cmd_step = 1'b0;
      check("load_entered", state_out, 3'b001);
      n = 0;
      i = 0;
      while (n < CELLS && i < 1000) begin
         bit_valid = (i % 3 != 2) && ($urandom_range(0, 4) != 0);
         bit_in    = 1'($urandom);
         cmd_run   = ($urandom_range(0, 5) == 0);
         cmd_step  = ($urandom_range(0, 5) == 0);
         if (bit_valid) begin
            n++;
            if (n == CELLS) begin
               gen_exp = '0;
               e = '{cyc + 1, gen_exp, CELLS, 0, 0};
               exp_q.push_back(e);
            end
         end
         i++;
         tick(1);
      end
      bit_valid = 1'b0;
      cmd_run   = 1'b0;
      cmd_step  = 1'b0;
      tick(3);
      check("load_idle_state", state_out, 3'b000);
      check("load_gen_count", gen_count, 0);
   endtask

   task automatic do_step(input bit noise);
      int unsigned c;
      exp_t e;
      c = cyc;
      cmd_step = 1'b1;
      gen_exp = gen_exp + 16'd1;
      e = '{c + 51, gen_exp, 0, CELLS, 1};
      exp_q.push_back(e);
      tick(1);
      cmd_step = 1'b0;
      if (noise) begin
         tick_to(c + 12);
         cmd_step = 1'b1; cmd_load = 1'b1; cmd_run = 1'b1;
         tick(1);
         cmd_step = 1'b0; cmd_load = 1'b0; cmd_run = 1'b0;
      end
      tick_to(c + 52);
      check("step_idle_state", state_out, 3'b000);
      check("step_gen_count", gen_count, gen_exp);
      tick(60);
   endtask

   // Free-run for ngen generations, then stop in COPY cycle 20 of the last one or in its WAIT.
   task automatic run_gens(input int unsigned p, input int unsigned ngen, input bit stop_in_wait);
      int unsigned c, sp, d;
      exp_t e;
      c = cyc;
      sp = 50 + p;
      period = 8'(p);
      cmd_run = 1'b1;
      for (int unsigned k = 1; k <= ngen; k++) begin
         e = '{c + 51 + (k - 1) * sp, 16'(gen_exp + 16'(k)), 0, CELLS, 1};
         exp_q.push_back(e);
      end
      gen_exp = gen_exp + 16'(ngen);
      d = c + 51 + (ngen - 1) * sp;
      tick(1);
      cmd_run = 1'b0;
      if (!stop_in_wait) begin
         tick_to(c + 1 + (ngen - 1) * sp + 20);
         check("stop_copy_state", state_out, 3'b011);
         cmd_stop = 1'b1;
         tick(1);
         cmd_stop = 1'b0;
         tick_to(d + 1);
      end else begin
         tick_to(d + 1);
         check("wait_state", state_out, 3'b100);
         cmd_stop = 1'b1;
         tick(1);
         cmd_stop = 1'b0;
      end
      check("run_stop_idle", state_out, 3'b000);
      check("run_stop_busy", busy, 0);
      check("run_gen_count", gen_count, gen_exp);
      tick(sp + 5);
   endtask

   task automatic reset_in_copy();
      int unsigned c;
      c = cyc;
      cmd_step = 1'b1;
      tick(1);
      cmd_step = 1'b0;
      tick_to(c + 11);
      check("pre_reset_copy", state_out, 3'b011);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      gen_exp = '0;
      check("rst_state", state_out, 0);
      check("rst_busy", busy, 0);
      check("rst_shift_en", grid_shift_en, 0);
      check("rst_shift_sel", grid_shift_sel, 0);
      check("rst_compute", grid_compute, 0);
      check("rst_bit_ready", bit_ready, 0);
      check("rst_done", done, 0);
      check("rst_gen_count", gen_count, 0);
      tick(60);
   endtask

   initial begin
      tick(3);
      reset = 1'b0;
      check("init_state", state_out, 0);
      check("init_busy", busy, 0);
      check("init_gen_count", gen_count, 0);
      check("init_done", done, 0);
      check("init_bit_ready", bit_ready, 0);
      check("init_shift_en", grid_shift_en, 0);
      check("init_compute", grid_compute, 0);
      cmd_stop = 1'b1;
      tick(1);
      cmd_stop = 1'b0;
      check("stop_in_idle", state_out, 0);

      do_load(1'b0);
      do_step(1'b0);
      run_gens(5, 3, 1'b0);
      run_gens(0, 2, 1'b0);
      run_gens(10, 2, 1'b1);
      do_load(1'b1);
      do_step(1'b1);
      reset_in_copy();
      do_step(1'b0);

      for (int r = 0; r < 4; r++) begin
         if ($urandom_range(0, 1) == 1)
            run_gens($urandom_range(3, 20), $urandom_range(1, 3), 1'b1);
         else
            run_gens($urandom_range(0, 20), $urandom_range(1, 3), 1'b0);
      end

`ifdef LIFE_STILL_DETECT_EN
      begin
         int unsigned c;
         exp_t e;
         do_load(1'b0);
         check("still_after_load", still, 0);
         grid_new_bit = 1'b0;
         c = cyc;
         period = 8'd3;
         cmd_run = 1'b1;
         gen_exp = gen_exp + 16'd1;
         e = '{c + 51, gen_exp, 0, CELLS, 1};
         exp_q.push_back(e);
         tick(1);
         cmd_run = 1'b0;
         tick_to(c + 53);
         check("still_flag", still, 1);
         check("still_halt_state", state_out, 0);
         tick(60);
         grid_new_bit = 1'b1;
      end
`endif

      tick(5);
      check("pending_done", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
